// File: rtl/te_window_ctrl.sv
// -----------------------------------------------------------------------------
// te_window_ctrl
//
// Sequencer for the 3x3 transmission-estimation filter datapath (mean filter
// and edge-directed filter). It accepts a raster pixel stream, tracks the
// column/row position, drives the line-buffer / window shift enable, flags
// when the window registers hold a full 3x3 neighbourhood, and carries that
// flag through the fixed-latency filter pipeline. The delayed flag becomes
// out_valid, out_last and the end-of-frame pulse.
//
// Handshake: a pixel is transferred in every cycle where in_valid and
// in_ready are both high (lb_shift_en = in_valid & in_ready). in_valid may
// be raised or dropped at any time; in_ready is high only in RUN and does not
// depend on in_valid. Nothing downstream can stall: out_valid is a pure
// delay of win_valid.
//
// Optional feature (macro TE_WINDOW_ERR_EN): when defined, err is a sticky
// flag set by a start pulse while busy, or by in_valid in FLUSH or DONE. It
// clears only on rst. When undefined, err is tied low.
//
// Parameters:
//   IMG_WIDTH   pixels per line (>=3)
//   IMG_HEIGHT  lines per frame (>=3)
//   PIPE_LAT    filter datapath latency, window-valid to result (>=1)
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous, active-high reset
//   start        one-cycle pulse; begins a frame when idle
//   in_valid     upstream pixel valid
//   in_ready     controller can accept a pixel (high only in RUN)
//   lb_shift_en  in_valid & in_ready; shifts line buffers and window
//   win_valid    registered; window holds a full 3x3 neighbourhood
//   out_valid    filter result valid (win_valid delayed PIPE_LAT)
//   out_last     marks the final out_valid of the frame
//   frame_done   one-cycle pulse after the frame has drained
//   busy         high in any state except IDLE
//   err          sticky error flag (optional feature)
//   dbg_state    current FSM state (0 IDLE, 1 RUN, 2 FLUSH, 3 DONE)
// -----------------------------------------------------------------------------
module te_window_ctrl #(
    parameter int IMG_WIDTH  = 512,
    parameter int IMG_HEIGHT = 512,
    parameter int PIPE_LAT   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       lb_shift_en,
    output logic       win_valid,
    output logic       out_valid,
    output logic       out_last,
    output logic       frame_done,
    output logic       busy,
    output logic       err,
    output logic [1:0] dbg_state
);

    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);
    // Wide enough to hold the value PIPE_LAT.
    localparam int DRN_W = $clog2(PIPE_LAT + 1) + 1;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);
    localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(PIPE_LAT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state;
    state_t next_state;

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [DRN_W-1:0] drain;

    logic accept;
    logic last_pix;
    logic frame_start;

    // Delay lines for the window-valid flag and the last-window marker.
    logic [PIPE_LAT-1:0] valid_dly;
    logic [PIPE_LAT-1:0] last_dly;
    logic                win_last;

    // accept is derived from the state directly rather than from in_ready so
    // that no combinational path runs through the output port.
    assign accept      = in_valid & (state == S_RUN);
    assign last_pix    = (col == COL_LAST) & (row == ROW_LAST);
    assign frame_start = start & (state == S_IDLE);
    assign lb_shift_en = accept;
    assign dbg_state   = state;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and Moore outputs
    // ------------------------------------------------------------------
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        busy       = 1'b1;
        frame_done = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    next_state = S_RUN;
                end
            end
            S_RUN: begin
                in_ready = 1'b1;
                if (accept && last_pix) begin
                    next_state = S_FLUSH;
                end
            end
            S_FLUSH: begin
                // PIPE_LAT+1 cycles: one for win_valid to register, then
                // PIPE_LAT for it to reach out_valid.
                if (drain == DRN_LAST) begin
                    next_state = S_DONE;
                end
            end
            S_DONE: begin
                frame_done = 1'b1;
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Column / row position of the next pixel to be accepted
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (frame_start) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col == COL_LAST) begin
                col <= '0;
                // Wrap the row on the final pixel so the counter never
                // holds an out-of-frame value.
                if (row == ROW_LAST) begin
                    row <= '0;
                end else begin
                    row <= row + 1'b1;
                end
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Drain counter, active only in FLUSH
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drain <= '0;
        end else if (state == S_FLUSH) begin
            drain <= drain + 1'b1;
        end else begin
            drain <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Window-valid flag. Uses the pre-increment position: once the pixel at
    // (row, col) with row>=2 and col>=2 has shifted in, the window is
    // centred on (row-1, col-1).
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_valid <= 1'b0;
            win_last  <= 1'b0;
        end else begin
            win_valid <= accept & (row >= ROW_TWO) & (col >= COL_TWO);
            win_last  <= accept & last_pix;
        end
    end

    // ------------------------------------------------------------------
    // Pipeline tracking. The filter datapath has no enable, so these delay
    // lines shift every cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_dly <= '0;
            last_dly  <= '0;
        end else begin
            valid_dly[0] <= win_valid;
            last_dly[0]  <= win_last;
            for (int i = 1; i < PIPE_LAT; i++) begin
                valid_dly[i] <= valid_dly[i-1];
                last_dly[i]  <= last_dly[i-1];
            end
        end
    end

    assign out_valid = valid_dly[PIPE_LAT-1];
    assign out_last  = last_dly[PIPE_LAT-1];

    // ------------------------------------------------------------------
    // Sticky error flag
    // ------------------------------------------------------------------
`ifdef TE_WINDOW_ERR_EN
    logic err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if ((start && busy) ||
                     (in_valid && ((state == S_FLUSH) || (state == S_DONE)))) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_te_window_ctrl.sv
// Bench for te_window_ctrl. Two instances share the same stimulus:
// u1 with PIPE_LAT=1 and u4 with PIPE_LAT=4, both 8x6 frames.
// Everything runs in one process: the driver sets inputs 1 ns after the
// rising edge, and a model/scoreboard samples outputs at the falling edge.
module tb_te_window_ctrl;

  localparam int W = 8;
  localparam int H = 6;
`ifdef TE_WINDOW_ERR_EN
  localparam int ERR_ON = 1;
`else
  localparam int ERR_ON = 0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic in_valid = 1'b0;

  always #5 clk = ~clk;

  logic in_ready1, lb_shift_en1, win_valid1, out_valid1, out_last1, frame_done1, busy1, err1;
  logic in_ready4, lb_shift_en4, win_valid4, out_valid4, out_last4, frame_done4, busy4, err4;
  logic [1:0] dbg_state1, dbg_state4;

  te_window_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIPE_LAT(1)) u1 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .in_ready(in_ready1), .lb_shift_en(lb_shift_en1), .win_valid(win_valid1),
    .out_valid(out_valid1), .out_last(out_last1), .frame_done(frame_done1),
    .busy(busy1), .err(err1), .dbg_state(dbg_state1)
  );

  te_window_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIPE_LAT(4)) u4 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .in_ready(in_ready4), .lb_shift_en(lb_shift_en4), .win_valid(win_valid4),
    .out_valid(out_valid4), .out_last(out_last4), .frame_done(frame_done4),
    .busy(busy4), .err(err4), .dbg_state(dbg_state4)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic exp_q[$];     // expected win_valid history, newest at the back
  logic exp_last_q[$];
  logic pend_win, pend_last;
  int mcol, mrow;

  int n_acc1, n_acc4, n_win, n_out1, n_out4, n_last1, n_last4;
  int n_done1, n_done4, done1_cyc, done4_cyc, last_acc_cyc, first_win_acc;
  int err_at_last;
  logic prev_done1, prev_done4;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    exp_last_q.delete();
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(1'b0);
      exp_last_q.push_back(1'b0);
    end
    pend_win = 1'b0;
    pend_last = 1'b0;
    mcol = 0;
    mrow = 0;
    prev_done1 = 1'b0;
    prev_done4 = 1'b0;
  endtask

  task automatic clear_stats();
    n_acc1 = 0; n_acc4 = 0; n_win = 0; n_out1 = 0; n_out4 = 0;
    n_last1 = 0; n_last4 = 0; n_done1 = 0; n_done4 = 0;
    done1_cyc = -1; done4_cyc = -1; last_acc_cyc = -1; first_win_acc = -1;
    err_at_last = -1;
  endtask

  // Falling-edge monitor: compare against the model, then advance it.
  task automatic mon();
    if (rst) begin
      chk("rst_busy1", busy1, 0);
      chk("rst_ready1", in_ready1, 0);
      chk("rst_win1", win_valid1, 0);
      chk("rst_out1", out_valid1, 0);
      chk("rst_done1", frame_done1, 0);
      chk("rst_err1", err1, 0);
      chk("rst_state1", dbg_state1, 0);
      chk("rst_out4", out_valid4, 0);
      chk("rst_busy4", busy4, 0);
      clear_model();
      return;
    end
    chk("win1", win_valid1, pend_win);
    chk("win4", win_valid4, pend_win);
    chk("out1", out_valid1, exp_q[3]);
    chk("last1", out_last1, exp_last_q[3]);
    chk("out4", out_valid4, exp_q[0]);
    chk("last4", out_last4, exp_last_q[0]);
    if (prev_done1) chk("busy_after_done1", busy1, 0);
    if (prev_done4) chk("busy_after_done4", busy4, 0);
    if (frame_done1) begin
      chk("busy_at_done1", busy1, 1);
      n_done1++;
      done1_cyc = cyc;
    end
    if (frame_done4) begin
      n_done4++;
      done4_cyc = cyc;
    end
    prev_done1 = frame_done1;
    prev_done4 = frame_done4;
    n_win += int'(win_valid1);
    n_out1 += int'(out_valid1);
    n_out4 += int'(out_valid4);
    n_last1 += int'(out_last1);
    n_last4 += int'(out_last4);
    if (win_valid1 && first_win_acc < 0) first_win_acc = n_acc1;
    void'(exp_q.pop_front());
    void'(exp_last_q.pop_front());
    exp_q.push_back(pend_win);
    exp_last_q.push_back(pend_last);
    n_acc4 += int'(lb_shift_en4);
    if (lb_shift_en1) begin
      n_acc1++;
      last_acc_cyc = cyc;
      if (n_acc1 == W * H) err_at_last = int'(err1);
      pend_win = (mrow >= 2) && (mcol >= 2);
      pend_last = (mrow == H - 1) && (mcol == W - 1);
      if (mcol == W - 1) begin
        mcol = 0;
        mrow++;
      end else begin
        mcol++;
      end
    end else begin
      pend_win = 1'b0;
      pend_last = 1'b0;
    end
  endtask

  // One clock: monitor at the falling edge, return 1 ns after the rising edge.
  task automatic tick();
    @(negedge clk);
    mon();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic start_frame();
    clear_stats();
    clear_model();
    in_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  function automatic logic pat(input int mode, input int k);
    case (mode)
      1: return (k % 2) == 0;
      2: return (k % 3) != 2;
      default: return 1'b1;
    endcase
  endfunction

  // Feed pixels until the full frame is accepted or until stop_at accepts.
  task automatic feed(input int mode, input int start_at, input int stop_at);
    int k;
    bit mid_done;
    k = 0;
    mid_done = 0;
    while (n_acc1 < stop_at && k < 400) begin
      in_valid = pat(mode, k);
      start = 1'b0;
      if (start_at != 0 && !mid_done && n_acc1 == start_at) begin
        start = 1'b1;
        mid_done = 1;
      end
      tick();
      k++;
    end
    start = 1'b0;
    if (k >= 400) chk("feed_timeout", n_acc1, stop_at);
  endtask

  task automatic drain(input bit hold);
    int k;
    in_valid = hold;
    k = 0;
    while (n_done4 == 0 && k < 40) begin
      tick();
      k++;
    end
    if (k >= 40) chk("drain_timeout", n_done4, 1);
    repeat (3) tick();
    in_valid = 1'b0;
    repeat (2) tick();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int mode;        // 0 continuous, 1 alternating 1-0, 2 pattern 1-1-0
    int start_at;    // accept count at which a stray start is pulsed (0 none)
    bit hold;        // keep in_valid high through FLUSH/DONE
    int exp_acc;
    int exp_win;
    int exp_first;   // accept number preceding the first win_valid
    int exp_lat1;    // cycles from last accept to frame_done, PIPE_LAT=1
    int exp_lat4;    // same, PIPE_LAT=4
    int exp_err_mid; // err at the last accept
    int exp_err_end;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{0, 0, 1'b0, 48, 24, 19, 3, 6, 0, 0};
    vecs[1] = '{1, 0, 1'b0, 48, 24, 19, 3, 6, 0, 0};
    vecs[2] = '{0, 0, 1'b1, 48, 24, 19, 3, 6, 0, ERR_ON};
    vecs[3] = '{2, 0, 1'b1, 48, 24, 19, 3, 6, 0, ERR_ON};
    vecs[4] = '{0, 10, 1'b0, 48, 24, 19, 3, 6, ERR_ON, ERR_ON};

    clear_model();
    clear_stats();
    do_reset();
    chk("post_rst_state1", dbg_state1, 0);
    chk("post_rst_busy4", busy4, 0);

    for (int v = 0; v < 5; v++) begin
      do_reset();
      start_frame();
      chk("run_state1", dbg_state1, 1);
      feed(vecs[v].mode, vecs[v].start_at, W * H);
      drain(vecs[v].hold);
      chk("acc1", n_acc1, vecs[v].exp_acc);
      chk("acc4", n_acc4, vecs[v].exp_acc);
      chk("win_count", n_win, vecs[v].exp_win);
      chk("out1_count", n_out1, vecs[v].exp_win);
      chk("out4_count", n_out4, vecs[v].exp_win);
      chk("last1_count", n_last1, 1);
      chk("last4_count", n_last4, 1);
      chk("done1_count", n_done1, 1);
      chk("done4_count", n_done4, 1);
      chk("first_win_acc", first_win_acc, vecs[v].exp_first);
      chk("done1_lat", done1_cyc - last_acc_cyc, vecs[v].exp_lat1);
      chk("done4_lat", done4_cyc - last_acc_cyc, vecs[v].exp_lat4);
      chk("err_mid", err_at_last, vecs[v].exp_err_mid);
      chk("err1_end", err1, vecs[v].exp_err_end);
      chk("err4_end", err4, vecs[v].exp_err_end);
    end

    // Asynchronous reset in row 3, then a full clean frame.
    do_reset();
    start_frame();
    feed(0, 0, 27);
    #2;
    rst = 1'b1;
    #1;
    chk("async_busy1", busy1, 0);
    chk("async_ready1", in_ready1, 0);
    chk("async_win1", win_valid1, 0);
    chk("async_out1", out_valid1, 0);
    chk("async_state1", dbg_state1, 0);
    chk("async_shift1", lb_shift_en1, 0);
    tick();
    #2;
    rst = 1'b0;
    in_valid = 1'b0;
    clear_stats();
    repeat (10) tick();
    chk("abort_done1", n_done1, 0);
    chk("abort_done4", n_done4, 0);
    chk("abort_idle1", dbg_state1, 0);
    start_frame();
    feed(0, 0, W * H);
    drain(1'b0);
    chk("rerun_out1", n_out1, 24);
    chk("rerun_out4", n_out4, 24);
    chk("rerun_done1", n_done1, 1);

    // Back-to-back: start during frame_done is ignored, one cycle later taken.
    do_reset();
    start_frame();
    feed(0, 0, W * H);
    in_valid = 1'b0;
    begin
      int k;
      k = 0;
      while (!frame_done1 && k < 20) begin
        tick();
        k++;
      end
      chk("b2b_done_seen", frame_done1, 1);
    end
    start = 1'b1;
    tick();
    chk("b2b_ignored_state", dbg_state1, 0);
    chk("b2b_ignored_busy", busy1, 0);
    tick();
    start = 1'b0;
    chk("b2b_taken_state", dbg_state1, 1);
    chk("b2b_taken_ready", in_ready1, 1);
    do_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/te_window_ctrl.md
Name: te_window_ctrl

Overview:
- Sequencer for the 3x3 transmission-estimation filter datapath: the mean filter and the edge-directed filter blocks.
- Accepts a raster pixel stream over a valid/ready handshake and counts columns and rows.
- Generates the shift enable for the line buffers and window registers.
- Flags when a complete 3x3 neighbourhood is present.
- Tracks that flag through the fixed-latency filter pipeline to produce an aligned output valid, last-pixel marker and frame-done pulse.

Parameters:
- IMG_WIDTH, 512, pixels per line (>=3)
- IMG_HEIGHT, 512, lines per frame (>=3)
- PIPE_LAT, 1, filter datapath latency in cycles from window-valid to result (>=1)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a frame when idle
- in_valid  in  1  upstream pixel valid
- in_ready  out  1  controller can accept a pixel
- lb_shift_en  out  1  combinational; in_valid & in_ready; shifts line buffers/window
- win_valid  out  1  registered; window registers hold a full 3x3 neighbourhood this cycle
- out_valid  out  1  filter result valid (win_valid delayed PIPE_LAT)
- out_last  out  1  qualifies final out_valid of frame
- frame_done  out  1  one-cycle pulse after frame drained
- busy  out  1  high in any state except IDLE
- err  out  1  sticky error flag (see Optional Feature)

Behaviour:
- Reset (async, active-high): state IDLE. All outputs are 0; col, row, drain counter and valid delay line are cleared. A reset mid-frame aborts the frame with no frame_done.
- FSM states: IDLE, RUN, FLUSH, DONE.
- IDLE: in_ready=0. start=1 clears col/row and moves to RUN next cycle.
- RUN: in_ready=1.
  - On each accept (in_valid & in_ready), col increments. At col==IMG_WIDTH-1, col wraps to 0 and row increments.
  - in_valid=0 holds the counters; win_valid is 0 the next cycle.
- win_valid <= accept & (row>=2) & (col>=2), evaluated on the pre-increment counter values. The window centre is (row-1, col-1). Outputs per frame: (IMG_WIDTH-2)*(IMG_HEIGHT-2).
- Accepting pixel (IMG_HEIGHT-1, IMG_WIDTH-1) moves the FSM to FLUSH. in_ready is 0 from the next cycle.
- FLUSH: in_ready=0. The drain counter counts PIPE_LAT+1 cycles so the last win_valid propagates, then the FSM moves to DONE.
- out_valid is a PIPE_LAT-deep shift register of win_valid. It is never stalled, because the datapath has no enable.
- out_last=1 coincides with the out_valid derived from the final window of the frame.
- DONE: frame_done=1 for exactly one cycle, then the FSM returns to IDLE.
- Counter widths: $clog2(IMG_WIDTH) and $clog2(IMG_HEIGHT). No other arithmetic.
- start while busy is ignored and counters are unaffected. start and reset asserted together: reset wins.
- in_valid while in IDLE, FLUSH or DONE is not accepted (in_ready=0), and there is no side effect.
- Back-to-back frames: start in the cycle frame_done is high is ignored. start one cycle later is accepted.

Optional Feature:
- Macro TE_WINDOW_ERR_EN.
- When defined, err is set for any of these:
  - start while busy;
  - in_valid asserted in FLUSH or DONE (upstream overrun).
- Once set, err stays high until rst.
- When undefined, err is tied to 0 and those events are silently ignored.

Test Plan:
- IMG_WIDTH=8, IMG_HEIGHT=6, PIPE_LAT=1; start, then 48 pixels with in_valid held high -> exactly 24 out_valid pulses. First win_valid is the cycle after the 19th accept (row 2, col 2). out_last on the 24th. frame_done 3 cycles after the last accept (FLUSH 2 cycles, then DONE). busy falls the cycle after frame_done.
- Same frame with in_valid toggled 1-0-1-0 -> the 24 outputs still arrive, each win_valid only the cycle after an accept, and the counters freeze on gaps.
- PIPE_LAT=4 -> out_valid pattern equals the win_valid pattern delayed 4 cycles. frame_done arrives 6 cycles after the last accept.
- Assert rst for 1 cycle mid-row 3, asynchronously between edges -> outputs clear immediately, state IDLE, no frame_done. A subsequent start plus a full frame gives 24 outputs.
- start pulsed during RUN at row 1 -> counters unchanged and the frame completes normally. With TE_WINDOW_ERR_EN, err=1 from the next cycle and stays 1. Without it, err=0.
- in_valid held high through FLUSH/DONE -> no extra accepts, lb_shift_en=0. With TE_WINDOW_ERR_EN, err sets in the first FLUSH cycle.
